serial_subtractor: RTL

- Bit-serial N-bit subtractor that computes diff = a - b - bin, LSB first, one bit per clock.
- Built from a single full-subtractor cell plus a borrow register. It is the inverse-arithmetic counterpart of the team's ripple adder blocks.
- Used in area-constrained datapaths where N cycles of latency is acceptable.
- Operands arrive on a valid/ready input port. The result leaves on a valid/ready output port.

---
 rtl/serial_arith_pkg.sv | 10 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 106 ++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic blocks (subtractor today, adder later).
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    import serial_arith_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH + 1);

    sub_state_t       state;
    sub_state_t       state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             bo_bit;
    logic             in_ready_d;
    logic             out_valid_d;

    full_subtractor u_fs (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (brw),
        .d  (d_bit),
        .bo (bo_bit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the WIDTH-th RUN edge is the one seeing cnt == WIDTH-1
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = RUN;
            RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state and registered below
    always_comb begin
        in_ready_d  = (state_nxt == IDLE);
        out_valid_d = (state_nxt == DONE);
    end

    // Handshake registers and serial datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            diff_sh   <= '0;
            brw       <= 1'b0;
            cnt       <= '0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh <= a;
                        b_sh <= b;
                        brw  <= bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= (diff_sh >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
                    brw     <= bo_bit;
                    cnt     <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_sh;
    assign bout = brw;

endmodule
